// File: rtl/servo_pkg.sv
// Shared definitions for the pan/tilt servo path: parser states and the
// position word layout that the proportional controller also consumes.
package servo_pkg;

  typedef enum logic [1:0] {
    HUNT1   = 2'd0,
    HUNT2   = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } frame_state_t;

  localparam int PAYLOAD_LEN = 6;
  localparam int FRAME_LEN   = 9;
  localparam int POS_W       = 8 * PAYLOAD_LEN;

  localparam int X_LSB = 0;
  localparam int Y_LSB = 16;
  localparam int Z_LSB = 32;

endpackage

// File: rtl/idle_timeout.sv
// Idle-gap watchdog: counts enabled cycles since the last clear and flags
// (registered) once the count sits at TIMEOUT_CYCLES-1.
module idle_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_expired;

  // Count holds at the terminal value so the flag stays asserted until cleared.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_expired <= (w_cnt_nxt == LAST);
    end
  end

  assign o_expired = r_expired;

endmodule

// File: rtl/coord_frame_parser.sv
// Frames the host coordinate byte stream (A5 5A + 6 payload + XOR chk) and
// publishes each verified frame as a 48-bit position with a 1-cycle strobe.
module coord_frame_parser
  import servo_pkg::*;
#(
  parameter logic [7:0] SYNC0          = 8'hA5,
  parameter logic [7:0] SYNC1          = 8'h5A,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         ERR_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [POS_W-1:0]   position,
  output logic               coord_valid,
  output logic [ERR_W-1:0]   frame_err_cnt,
  output logic               in_frame
);

  frame_state_t     r_state, w_state_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_xor, w_xor_nxt;
  logic [POS_W-1:0] r_shadow, w_shadow_nxt;
  logic [POS_W-1:0] r_position, w_position_nxt;
  logic             r_coord_valid, w_coord_valid_nxt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_err_inc;
  logic             w_expired;

  idle_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (rx_valid || (r_state == HUNT1)),
    .i_enable (r_state != HUNT1),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_xor_nxt         = r_xor;
    w_shadow_nxt      = r_shadow;
    w_position_nxt    = r_position;
    w_coord_valid_nxt = 1'b0;
    w_err_inc         = 1'b0;

    // A byte arriving in the terminal-count cycle takes priority over the timeout.
    case (r_state)
      HUNT1: begin
        if (rx_valid && (rx_data == SYNC0)) begin
          w_state_nxt = HUNT2;
        end
      end
      HUNT2: begin
        if (rx_valid) begin
          if (rx_data == SYNC1) begin
            w_state_nxt = PAYLOAD;
            w_idx_nxt   = '0;
            w_xor_nxt   = '0;
          end else if (rx_data != SYNC0) begin
            w_state_nxt = HUNT1;
          end
        end else if (w_expired) begin
          w_state_nxt = HUNT1;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          w_shadow_nxt[{r_idx, 3'b000} +: 8] = rx_data;
          w_xor_nxt = r_xor ^ rx_data;
          if (r_idx == 3'(PAYLOAD_LEN - 1)) begin
            w_state_nxt = CHECK;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else if (w_expired) begin
          w_state_nxt = HUNT1;
          w_err_inc   = 1'b1;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          w_state_nxt = HUNT1;
          if (rx_data == r_xor) begin
            w_position_nxt    = r_shadow;
            w_coord_valid_nxt = 1'b1;
          end else begin
            w_err_inc = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nxt = HUNT1;
          w_err_inc   = 1'b1;
        end
      end
      default: w_state_nxt = HUNT1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= HUNT1;
      r_idx         <= '0;
      r_xor         <= '0;
      r_shadow      <= '0;
      r_position    <= '0;
      r_coord_valid <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_xor         <= w_xor_nxt;
      r_shadow      <= w_shadow_nxt;
      r_position    <= w_position_nxt;
      r_coord_valid <= w_coord_valid_nxt;
      if (w_err_inc && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign position      = r_position;
  assign coord_valid   = r_coord_valid;
  assign frame_err_cnt = r_err_cnt;
  assign in_frame      = (r_state != HUNT1);

endmodule

// File: doc/coord_frame_parser.md
# coord_frame_parser

Upstream stage of the pan/tilt servo controller. It takes the byte stream from the UART receiver that carries target coordinates from the host vision pipeline, finds frame boundaries, and checks each frame's checksum. Each good frame becomes a 48-bit packed position with a one-cycle `coord_valid` pulse for the proportional controller. Bad, truncated or stalled frames are dropped and counted, and never reach the servos.

## Interface
- `SYNC0`, 8'hA5: first header byte.
- `SYNC1`, 8'h5A: second header byte.
- `TIMEOUT_CYCLES`, 100000: maximum number of idle clocks allowed between bytes inside a frame (1 ms at 100 MHz).
- `ERR_W`, 8: width of the error counter.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `position`  out  48  {z[15:0], y[15:0], x[15:0]}, holding the last good frame.
- `coord_valid`  out  1  one-cycle pulse when `position` updates.
- `frame_err_cnt`  out  ERR_W  saturating count of dropped frames.
- `in_frame`  out  1  high while the state is not HUNT1.

## Operation
- Frame format, 9 bytes: SYNC0, SYNC1, x_lo, x_hi, y_lo, y_hi, z_lo, z_hi, chk.
- chk is the XOR of the 6 payload bytes.
- Payload values are little-endian unsigned 16-bit.
- States: HUNT1, HUNT2, PAYLOAD, CHECK. Bytes are processed only in cycles where `rx_valid`=1.
  - HUNT1: byte==SYNC0 → HUNT2; otherwise stay.
  - HUNT2: byte==SYNC1 → PAYLOAD, clear the byte index and the running XOR.
  - HUNT2: byte==SYNC0 → stay in HUNT2, so A5 A5 5A still syncs. Any other byte → HUNT1, no error counted.
  - PAYLOAD: store the byte into shadow register[idx] and XOR it into the running checksum.
  - PAYLOAD: when idx==5 → CHECK.
  - CHECK, byte==running XOR: copy the shadow register to `position`, pulse `coord_valid`, go to HUNT1.
  - CHECK, mismatch: increment `frame_err_cnt`, go to HUNT1, leave `position` unchanged.
- Timeout:
  - The idle counter runs in HUNT2, PAYLOAD and CHECK. It clears on every `rx_valid` and on entry to HUNT2.
  - When it reaches TIMEOUT_CYCLES-1 with no `rx_valid` → HUNT1.
  - A timeout in PAYLOAD or CHECK counts as an error. A timeout in HUNT2 does not.
- If `rx_valid` and the timeout terminal count land in the same cycle, the byte wins: it is processed and no timeout occurs.
- `frame_err_cnt` saturates at all-ones and never wraps.
- The shadow payload is not visible on `position` until the checksum passes, so `position` never carries a partial frame.

## Timing
- Reset values:
  - `position`=0, `coord_valid`=0, `frame_err_cnt`=0, `in_frame`=0.
  - State HUNT1, idle counter 0, shadow register and running XOR 0.
- Latency:
  - `position` and `coord_valid` update on the clock edge that samples the chk byte's `rx_valid`, and are visible the next cycle.
  - `coord_valid` is high for exactly 1 cycle.
- Throughput: back-to-back `rx_valid` every cycle is supported; a new frame's SYNC0 may arrive in the cycle right after chk.
- All outputs are registered; there are no combinational paths from input to output.
- Reset asserted mid-frame drops the frame without counting an error. After release the block waits for SYNC0.

## Structure
- Package `servo_pkg`:
  - State enum `frame_state_t` (HUNT1, HUNT2, PAYLOAD, CHECK).
  - Localparams for the payload length (6), the frame length (9), and the position field offsets X_LSB=0, Y_LSB=16, Z_LSB=32, shared with the controller.
- One sub-module, `idle_timeout`: a counter with `clear`, `enable` and a registered `expired` output, parameterised by TIMEOUT_CYCLES.
- Everything else lives in one FSM module.

## Test plan
- Send A5 5A 34 12 78 56 BC 9A 2E → `position`=48'h9ABC_5678_1234, one `coord_valid` pulse, `frame_err_cnt`=0.
- Send the same frame with chk=2F → no pulse, `position` holds its previous value, `frame_err_cnt`=1.
- Send 00 A5 A5 5A followed by the good payload and chk → accepted, `position`=48'h9ABC_5678_1234.
- Send the header plus 3 payload bytes, then idle TIMEOUT_CYCLES (set to 16 in the bench) → back to HUNT1, `frame_err_cnt`+1. A following good frame is accepted.
- Force 300 bad frames with ERR_W=8 → `frame_err_cnt` stops at 255.
- Assert `rst` in the middle of the payload → all outputs go to 0 the same cycle. A good frame after release produces exactly one pulse.
